// File: rtl/fifo_status.sv
// Parametrised synchronous FIFO with show-ahead output, occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module fifo_status #(
  parameter  int DEPTH    = 4,
  parameter  int WIDTH    = 2,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             push,
  input  logic             pop,
  input  logic             clear_err,
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;
  logic w_ovf_set;
  logic w_udf_set;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A simultaneous pop frees the slot on a full FIFO; a pop on an empty one is ignored.
  assign w_wr_en   = push && (!w_full || pop);
  assign w_rd_en   = pop && !w_empty;
  assign w_ovf_set = push && w_full && !pop;
  assign w_udf_set = pop && w_empty && !push;

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_mem[r_wr] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wr <= f_ptr_next(r_wr);
      if (w_rd_en) r_rd <= f_ptr_next(r_rd);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // New error events take priority over clear_err in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set || (r_overflow && !clear_err);
      r_underflow <= w_udf_set || (r_underflow && !clear_err);
    end
  end

  assign out          = w_empty ? '0 : r_mem[r_rd];
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_status.sv
// Bench for fifo_status: directed vector table on a 4x2 instance, then a
// queue-based reference model driving a 5x4 instance with fill/drain and random traffic.
module tb_fifo_status;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DEPTH=4, WIDTH=2 instance
  logic       r4_rst, r4_psh, r4_pop, r4_clr;
  logic [1:0] r4_din;
  logic [1:0] w4_out;
  logic [2:0] w4_cnt;
  logic       w4_full, w4_empty, w4_af, w4_ae, w4_ovf, w4_udf;

  fifo_status #(.DEPTH(4), .WIDTH(2)) u_dut4 (
    .clk(clk), .reset(r4_rst), .in(r4_din), .push(r4_psh), .pop(r4_pop),
    .clear_err(r4_clr), .out(w4_out), .full(w4_full), .empty(w4_empty),
    .count(w4_cnt), .almost_full(w4_af), .almost_empty(w4_ae),
    .overflow(w4_ovf), .underflow(w4_udf)
  );

  // DEPTH=5, WIDTH=4 instance
  logic       r5_rst, r5_psh, r5_pop, r5_clr;
  logic [3:0] r5_din;
  logic [3:0] w5_out;
  logic [2:0] w5_cnt;
  logic       w5_full, w5_empty, w5_af, w5_ae, w5_ovf, w5_udf;

  fifo_status #(.DEPTH(5), .WIDTH(4)) u_dut5 (
    .clk(clk), .reset(r5_rst), .in(r5_din), .push(r5_psh), .pop(r5_pop),
    .clear_err(r5_clr), .out(w5_out), .full(w5_full), .empty(w5_empty),
    .count(w5_cnt), .almost_full(w5_af), .almost_empty(w5_ae),
    .overflow(w5_ovf), .underflow(w5_udf)
  );

  typedef struct {
    logic       rst, psh, pop, clr;
    logic [1:0] din;
    logic [1:0] eout;
    int         ecnt;
    logic       efull, eempty, eaf, eae, eovf, eudf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, psh, pop, clr, input logic [1:0] din,
                              input logic [1:0] eout, input int ecnt,
                              input logic efull, eempty, eaf, eae, eovf, eudf);
    vec_t v;
    v.rst = rst; v.psh = psh; v.pop = pop; v.clr = clr; v.din = din;
    v.eout = eout; v.ecnt = ecnt; v.efull = efull; v.eempty = eempty;
    v.eaf = eaf; v.eae = eae; v.eovf = eovf; v.eudf = eudf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model for the 5-deep instance: a plain queue plus two sticky bits.
  logic [3:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic step5(input string tag, input logic rst, psh, pop, clr, input logic [3:0] d);
    bit   was_full, was_empty, set_o, set_u;
    logic [3:0] drop;
    int   n;
    r5_rst = rst; r5_psh = psh; r5_pop = pop; r5_clr = clr; r5_din = d;
    was_full  = (m_q.size() == 5);
    was_empty = (m_q.size() == 0);
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      set_o = psh && was_full && !pop;
      set_u = pop && was_empty && !psh;
      if (pop && !was_empty) drop = m_q.pop_front();
      if (psh && (!was_full || pop)) m_q.push_back(d);
      if (clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      m_ovf = m_ovf | set_o;
      m_udf = m_udf | set_u;
    end
    @(posedge clk);
    #1;
    n = m_q.size();
    chk({tag, "_out"},   int'(w5_out),   (n == 0) ? 0 : int'(m_q[0]));
    chk({tag, "_count"}, int'(w5_cnt),   n);
    chk({tag, "_full"},  int'(w5_full),  int'(n == 5));
    chk({tag, "_empty"}, int'(w5_empty), int'(n == 0));
    chk({tag, "_af"},    int'(w5_af),    int'(n >= 4));
    chk({tag, "_ae"},    int'(w5_ae),    int'(n <= 1));
    chk({tag, "_ovf"},   int'(w5_ovf),   int'(m_ovf));
    chk({tag, "_udf"},   int'(w5_udf),   int'(m_udf));
  endtask

  logic [3:0] data_ctr;

  initial begin
    r4_rst = 1'b1; r4_psh = 1'b0; r4_pop = 1'b0; r4_clr = 1'b0; r4_din = '0;
    r5_rst = 1'b1; r5_psh = 1'b0; r5_pop = 1'b0; r5_clr = 1'b0; r5_din = '0;
    repeat (2) @(posedge clk);
    #1;

    //             rst psh pop clr din    out  cnt full emp af ae ovf udf
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 2'b11, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 2'b11, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 2'b11, 3, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 2'b11, 4, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b10, 2'b11, 4, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b01, 2'b01, 4, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b00, 2'b10, 3, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b00, 2'b01, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 2'b11, 2'b11, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2'b10, 2'b10, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 2'b10, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b11, 2'b10, 3, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 2'b10, 4, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 2'b10, 4, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 2'b00, 2'b01, 3, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 2'b11, 2'b00, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      r4_rst = tbl[i].rst; r4_psh = tbl[i].psh; r4_pop = tbl[i].pop;
      r4_clr = tbl[i].clr; r4_din = tbl[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("d4_v%0d_out", i),   int'(w4_out),   int'(tbl[i].eout));
      chk($sformatf("d4_v%0d_count", i), int'(w4_cnt),   tbl[i].ecnt);
      chk($sformatf("d4_v%0d_full", i),  int'(w4_full),  int'(tbl[i].efull));
      chk($sformatf("d4_v%0d_empty", i), int'(w4_empty), int'(tbl[i].eempty));
      chk($sformatf("d4_v%0d_af", i),    int'(w4_af),    int'(tbl[i].eaf));
      chk($sformatf("d4_v%0d_ae", i),    int'(w4_ae),    int'(tbl[i].eae));
      chk($sformatf("d4_v%0d_ovf", i),   int'(w4_ovf),   int'(tbl[i].eovf));
      chk($sformatf("d4_v%0d_udf", i),   int'(w4_udf),   int'(tbl[i].eudf));
    end
    r4_psh = 1'b0; r4_pop = 1'b0; r4_clr = 1'b0;

    // 5-deep: reset, then three fill/drain passes that overrun both ends.
    step5("d5_rst", 1, 0, 0, 0, 4'h0);
    data_ctr = 4'h1;
    for (int pass = 0; pass < 3; pass++) begin
      for (int k = 0; k < 6; k++) begin
        step5($sformatf("d5_p%0d_fill%0d", pass, k), 0, 1, 0, 0, data_ctr);
        data_ctr = data_ctr + 4'h1;
      end
      for (int k = 0; k < 6; k++)
        step5($sformatf("d5_p%0d_drain%0d", pass, k), 0, 0, 1, (k == 0), 4'h0);
      step5($sformatf("d5_p%0d_clr", pass), 0, 0, 0, 1, 4'h0);
      // Offset the pointers so the next pass wraps mid-fill.
      step5($sformatf("d5_p%0d_skew", pass), 0, 1, 1, 0, data_ctr);
      data_ctr = data_ctr + 4'h1;
    end

    for (int c = 0; c < 400; c++)
      step5($sformatf("d5_rnd%0d", c), 1'b0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 4'($urandom));

    // Reset while holding three words with push still requested.
    step5("d5_drain_all", 1, 0, 0, 0, 4'h0);
    step5("d5_ld0", 0, 1, 0, 0, 4'h9);
    step5("d5_ld1", 0, 1, 0, 0, 4'hA);
    step5("d5_ld2", 0, 1, 0, 0, 4'hB);
    step5("d5_ovf_pre", 0, 0, 1, 0, 4'h0);
    step5("d5_ld3", 0, 1, 0, 0, 4'hC);
    step5("d5_rst_mid", 1, 1, 0, 0, 4'hD);
    step5("d5_post", 0, 0, 0, 0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
